pipe_ctrl_chain: RTL

//  Consumer of the opcode decoder's control word. Carries RegDst/ALUsrc/ALUop/Branch/MemRead/

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 21 ++
 rtl/pipe_ctrl_chain.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : ctrl_pkg
// Brief   : Pipeline control-word type, bubble constant, ALU-op and opcode codes.
// Revision: 1.0
// ============================================================================
package ctrl_pkg;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Load-use detector; a load in EX whose target feeds the ID operands.
// Revision: 1.0
// ============================================================================
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    output logic            stall
);

    // $0 is never a real dependency, so a load targeting it cannot stall
    assign stall = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_chain
// Brief   : ID/EX, EX/MEM, MEM/WB control registers with load-use stall and
//           branch/jump flush generation for a 5-stage pipeline.
// Revision: 1.0
// ============================================================================
module pipe_ctrl_chain
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_regdst,
    input  logic            id_alusrc,
    input  logic [1:0]      id_aluop,
    input  logic            id_branch,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_jump,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic            ex_regdst,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic [RA_W-1:0] ex_rt,
    output logic [RA_W-1:0] ex_rd,
    output logic [RA_W-1:0] ex_wreg,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_memtoreg,
    output logic            mem_regwrite,
    output logic [RA_W-1:0] mem_wreg,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic [RA_W-1:0] wb_wreg,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            br_taken
);

    ctrl_word_t      w_id_ctrl;
    ctrl_word_t      r_idex_ctrl;
    logic [RA_W-1:0] r_idex_rt;
    logic [RA_W-1:0] r_idex_rd;
    logic            w_stall;
    logic            w_idex_kill;

    logic            r_exmem_memread;
    logic            r_exmem_memwrite;
    logic            r_exmem_memtoreg;
    logic            r_exmem_regwrite;
    logic [RA_W-1:0] r_exmem_wreg;

    logic            r_memwb_memtoreg;
    logic            r_memwb_regwrite;
    logic [RA_W-1:0] r_memwb_wreg;

    assign w_id_ctrl = '{regdst:   id_regdst,
                         alusrc:   id_alusrc,
                         aluop:    id_aluop,
                         branch:   id_branch,
                         memread:  id_memread,
                         memwrite: id_memwrite,
                         memtoreg: id_memtoreg,
                         regwrite: id_regwrite};

    hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard_detect (
        .ex_memread (r_idex_ctrl.memread),
        .ex_rt      (r_idex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .stall      (w_stall)
    );

    // A taken branch overrides the stall: the stalled instruction is on the wrong path
    assign br_taken    = r_idex_ctrl.branch & ex_zero;
    assign pc_write    = br_taken | ~w_stall;
    assign ifid_write  = br_taken | ~w_stall;
    assign ifid_flush  = br_taken | (id_jump & ~w_stall);
    assign w_idex_kill = br_taken | w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_ctrl <= CTRL_BUBBLE;
            r_idex_rt   <= '0;
            r_idex_rd   <= '0;
        end else if (w_idex_kill) begin
            r_idex_ctrl <= CTRL_BUBBLE;
            r_idex_rt   <= '0;
            r_idex_rd   <= '0;
        end else begin
            r_idex_ctrl <= w_id_ctrl;
            r_idex_rt   <= id_rt;
            r_idex_rd   <= id_rd;
        end
    end

    assign ex_wreg = r_idex_ctrl.regdst ? r_idex_rd : r_idex_rt;

    // Older stages always advance so in-flight instructions retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_memtoreg <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_wreg     <= '0;
        end else begin
            r_exmem_memread  <= r_idex_ctrl.memread;
            r_exmem_memwrite <= r_idex_ctrl.memwrite;
            r_exmem_memtoreg <= r_idex_ctrl.memtoreg;
            r_exmem_regwrite <= r_idex_ctrl.regwrite;
            r_exmem_wreg     <= ex_wreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memwb_memtoreg <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_wreg     <= '0;
        end else begin
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_wreg     <= r_exmem_wreg;
        end
    end

    assign ex_alusrc    = r_idex_ctrl.alusrc;
    assign ex_aluop     = r_idex_ctrl.aluop;
    assign ex_regdst    = r_idex_ctrl.regdst;
    assign ex_branch    = r_idex_ctrl.branch;
    assign ex_memread   = r_idex_ctrl.memread;
    assign ex_memwrite  = r_idex_ctrl.memwrite;
    assign ex_memtoreg  = r_idex_ctrl.memtoreg;
    assign ex_regwrite  = r_idex_ctrl.regwrite;
    assign ex_rt        = r_idex_rt;
    assign ex_rd        = r_idex_rd;

    assign mem_memread  = r_exmem_memread;
    assign mem_memwrite = r_exmem_memwrite;
    assign mem_memtoreg = r_exmem_memtoreg;
    assign mem_regwrite = r_exmem_regwrite;
    assign mem_wreg     = r_exmem_wreg;

    assign wb_memtoreg  = r_memwb_memtoreg;
    assign wb_regwrite  = r_memwb_regwrite;
    assign wb_wreg      = r_memwb_wreg;

endmodule
`default_nettype wire
